// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the forwarding select encoding, the MUL sequencer state type,
// the PC register index and the legal MUL latency bounds.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mul_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 16;

  // Out-of-range latencies are pulled into the legal window so the
  // counter load value always fits in four bits.
  function automatic int clamp_mul_lat(input int lat);
    if (lat < MUL_LAT_MIN) begin
      return MUL_LAT_MIN;
    end else if (lat > MUL_LAT_MAX) begin
      return MUL_LAT_MAX;
    end
    return lat;
  endfunction

  // Memory-stage result wins over writeback; r15 reads the PC, never a bypass.
  function automatic fwd_sel_t fwd_select(
    input logic       regWriteM,
    input logic [3:0] wa3M,
    input logic       regWriteW,
    input logic [3:0] wa3W,
    input logic [3:0] ra
  );
    if (regWriteM && (wa3M == ra) && (ra != REG_PC)) begin
      return FWD_M;
    end else if (regWriteW && (wa3W == ra) && (ra != REG_PC)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Multi-cycle MUL sequencer: keeps a MUL parked in Execute for MUL_LAT
// cycles. MulHold_o covers every cycle but the last; MulDoneE_o marks the
// last cycle, when the datapath captures the product.
module mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE_i,
  output logic MulHold_o,
  output logic MulDoneE_o
);

  localparam int         LatEff  = clamp_mul_lat(MUL_LAT);
  localparam logic [3:0] CntLoad = (LatEff > 2) ? 4'(LatEff - 3) : 4'd0;

  mul_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State and down-counter registers; reset abandons any MUL in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and hold/done outputs; the issue cycle itself already holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    MulHold_o  = 1'b0;
    MulDoneE_o = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (MulStartE_i) begin
          MulHold_o = 1'b1;
          if (LatEff == 2) begin
            state_d = MS_DONE;
          end else begin
            state_d = MS_BUSY;
            cnt_d   = CntLoad;
          end
        end
      end
      MS_BUSY: begin
        MulHold_o = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = MS_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MS_DONE: begin
        MulDoneE_o = 1'b1;
        state_d    = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: E-stage forwarding
// selects, load-use and PC-write stalls/flushes, and the MUL hold.
// Optional feature macro HAZARD_STATS_EN adds saturating StallCnt/FlushCnt
// counters; without it those ports and registers do not exist.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulDoneE
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);

  logic ldrStall;
  logic pcWrPend;
  logic mulHold;

  mul_seq #(
    .MUL_LAT(MUL_LAT)
  ) u_mul_seq (
    .clk        (clk),
    .reset      (reset),
    .MulStartE_i(MulStartE),
    .MulHold_o  (mulHold),
    .MulDoneE_o (MulDoneE)
  );

  // Hazard detection and the stall/flush equations; a held MUL in E is
  // never flushed, and M takes a bubble behind it instead.
  always_comb begin
    ForwardAE = fwd_select(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
    ForwardBE = fwd_select(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
    ldrStall  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    pcWrPend  = PCSrcD || PCSrcE || PCSrcM;
    StallF    = ldrStall || pcWrPend || mulHold;
    StallD    = ldrStall || mulHold;
    StallE    = mulHold;
    FlushD    = pcWrPend || PCSrcW || BranchTakenE;
    FlushE    = (ldrStall || BranchTakenE) && !mulHold;
    FlushM    = mulHold;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt_q, stallCnt_d;
  logic [15:0] flushCnt_q, flushCnt_d;

  // Saturating event counters so a long run never wraps to a small value.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (StallD && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
    if (FlushE && (flushCnt_q != 16'hFFFF)) begin
      flushCnt_d = flushCnt_q + 16'd1;
    end
  end

  // Counter registers, cleared together with the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= 16'd0;
      flushCnt_q <= 16'd0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign StallCnt = stallCnt_q;
  assign FlushCnt = flushCnt_q;
`endif

endmodule
